riscv_periph_timer: RTL
=======================

// Module: riscv_periph_timer
// PURPOSE
//  Memory-mapped peripheral block on the core data port beside RiscVBus.
//  Provides a prescaled 64-bit free-running timer with CHANNELS compare/IRQ
//  channels and a buffered debug console TX FIFO.
//  Timer is readable at +0x08 and the console is writable at +0x04, both
//  relative to BASE_ADDR.
//  The system top routes data_read/data_write away from the bus whenever hit=1.
// PARAMETERS
//  BASE_ADDR        32'h40000000  window base; window size 0x20+4*CHANNELS bytes
//  CHANNELS         2             compare channels, 1..8
//  FIFO_DEPTH       8             console TX FIFO entries, power of 2, >=2
//  PRESCALE_DEFAULT 100           reset value of PRESCALE; tick period = PRESCALE+1 clocks
// PORTS
//  clock          in   1   single clock, rising edge
//  reset          in   1   asynchronous, active-low
//  data_address   in   32  core data address
//  data_width     in   2   0=byte 1=half 2=word
//  data_in        in   32  write data from core
//  data_read      in   1   read request, held until data_ready
//  data_write     in   1   write request, held until data_ready
//  data_out       out  32  read data, valid when data_ready=1
//  data_ready     out  1   1-cycle completion pulse
//  hit            out  1   combinational: data_address inside window
//  console_valid  out  1   FIFO head valid
//  console_data   out  8   FIFO head byte
//  console_ready  in   1   sink accepts head when valid&ready
//  irq            out  1   registered OR of (pending & enable)
// BEHAVIOUR
//  Register map (offset from BASE_ADDR):
//   0x04 CONSOLE_TX  W: push data_in[7:0]
//   0x08 TIMER_LO    R: timer[31:0]; read snapshots timer[63:32] into shadow
//   0x0C TIMER_HI    R: shadow
//   0x10 STATUS      R: [7:0] fifo count, [8] full, [9] empty
//   0x14 PRESCALE    RW
//   0x18 IRQ_EN      RW [CHANNELS-1:0]
//   0x1C IRQ_PEND    R; W1C
//   0x20+4k CMP[k]   RW
//  Reset (reset=0, async): timer=0, divider=0, PRESCALE=PRESCALE_DEFAULT,
//   CMP=0, IRQ_EN=0, IRQ_PEND=0, shadow=0, FIFO empty.
//   Outputs data_out=0, data_ready=0, console_valid=0, console_data=0, irq=0.
//  Access rule: request (read|write)&hit accepted at a rising edge -> data_ready=1
//   in the next cycle only. data_out holds the value sampled at the accept edge,
//   otherwise 0. The core drops the request in the ready cycle; no re-accept there.
//  Writes take effect at the accept edge.
//   Sub-word writes to any register other than CONSOLE_TX are ignored.
//   CONSOLE_TX accepts any width.
//   Unmapped offsets in the window: read 0, write ignored, ready still given.
//  CONSOLE_TX while FIFO full: not accepted, data_ready held 0 until a slot frees.
//   Push and pop in the same cycle when full: the pop frees the slot; push accepted next edge.
//  FIFO: pop on console_valid&console_ready. Simultaneous push+pop keeps count.
//   Pointers wrap modulo FIFO_DEPTH. console_data = head, registered.
//  Timer: divider counts 0..PRESCALE; at divider==PRESCALE -> divider=0, timer+=1 (tick).
//   Timer is 64-bit, wraps 2^64-1 -> 0.
//   PRESCALE write clears divider. PRESCALE=0 ticks every clock.
//  Compare: on a tick where the new timer[31:0]==CMP[k], set IRQ_PEND[k].
//   Set wins over a same-cycle W1C of that bit.
//   Writing CMP equal to the current timer does not set pending.
//  irq registered: irq(t+1) = |(IRQ_PEND & IRQ_EN)(t).
// TESTING
//  Release reset; read TIMER_LO after 505 clocks -> data_ready 1 cycle later, value 5.
//  Write PRESCALE=0, CMP[0]=10, IRQ_EN=1 -> IRQ_PEND=1 and irq=1 one cycle after timer hits 10.
//   W1C IRQ_PEND=1 -> irq drops.
//  console_ready=0; write 9 bytes 'A'..'I' -> 8 accepted, 9th stalls with data_ready=0.
//   console_ready=1 -> 9th completes; sink sees 'A'..'I' in order.
//  Force timer to 0x0000_0000_FFFF_FFFF; after a tick read LO=0, then HI -> 1.
//   HI does not change if a later tick occurs before the HI read.
//  Assert reset mid-stall with FIFO full and irq=1.
//   -> all outputs 0 immediately (async); STATUS reads empty after release.

Source files
------------

// File: rtl/riscv_periph_timer_if.sv
// ----------------------------------------------------------------------------
// riscv_periph_timer_if
//   Core data-port bundle between the CPU and the timer/console peripheral.
//   master: the core side (drives address, width, write data, read/write
//           requests; receives read data, ready pulse and window hit).
//   slave : the peripheral side (the mirror image).
//
//   data_address  32  core data address
//   data_width     2  0=byte 1=half 2=word
//   data_in       32  write data from core
//   data_read      1  read request, held until data_ready
//   data_write     1  write request, held until data_ready
//   data_out      32  read data, valid while data_ready=1
//   data_ready     1  one-cycle completion pulse
//   hit            1  combinational: address falls inside the peripheral window
// ----------------------------------------------------------------------------
interface riscv_periph_timer_if;
    logic [31:0] data_address;
    logic [1:0]  data_width;
    logic [31:0] data_in;
    logic        data_read;
    logic        data_write;
    logic [31:0] data_out;
    logic        data_ready;
    logic        hit;

    modport master (
        output data_address, data_width, data_in, data_read, data_write,
        input  data_out, data_ready, hit
    );

    modport slave (
        input  data_address, data_width, data_in, data_read, data_write,
        output data_out, data_ready, hit
    );
endinterface

// File: rtl/riscv_periph_timer.sv
// ----------------------------------------------------------------------------
// riscv_periph_timer
//   Memory-mapped peripheral sitting on the core data port next to RiscVBus.
//   Holds a prescaled 64-bit free-running timer, CHANNELS compare channels
//   that raise a level interrupt, and a small TX FIFO for a debug console.
//
// Ports
//   clock          rising-edge clock
//   reset          asynchronous, active-low
//   bus            data-port bundle (slave side), see riscv_periph_timer_if
//   console_valid  FIFO head valid
//   console_data   FIFO head byte (registered)
//   console_ready  sink accepts the head when console_valid & console_ready
//   irq            registered OR of (IRQ_PEND & IRQ_EN)
//
// Register map (byte offset from BASE_ADDR)
//   0x04 CONSOLE_TX  W  push data_in[7:0], any access width
//   0x08 TIMER_LO    R  timer[31:0]; the read also latches timer[63:32]
//   0x0C TIMER_HI    R  latched upper half
//   0x10 STATUS      R  [7:0] fifo count, [8] full, [9] empty
//   0x14 PRESCALE    RW tick period = PRESCALE+1 clocks; write clears divider
//   0x18 IRQ_EN      RW [CHANNELS-1:0]
//   0x1C IRQ_PEND    R, write-one-to-clear
//   0x20+4k CMP[k]   RW
// ----------------------------------------------------------------------------
module riscv_periph_timer #(
    parameter logic [31:0] BASE_ADDR        = 32'h4000_0000,
    parameter int          CHANNELS         = 2,
    parameter int          FIFO_DEPTH       = 8,
    parameter logic [31:0] PRESCALE_DEFAULT = 32'd100
) (
    input  logic                 clock,
    input  logic                 reset,
    riscv_periph_timer_if.slave  bus,
    output logic                 console_valid,
    output logic [7:0]           console_data,
    input  logic                 console_ready,
    output logic                 irq
);

    localparam int          PW     = $clog2(FIFO_DEPTH);
    localparam int          CW     = PW + 1;
    localparam logic [31:0] WINDOW = 32'h20 + 32'(4 * CHANNELS);

    localparam logic [5:0] IDX_CONSOLE  = 6'd1;
    localparam logic [5:0] IDX_TIMER_LO = 6'd2;
    localparam logic [5:0] IDX_TIMER_HI = 6'd3;
    localparam logic [5:0] IDX_STATUS   = 6'd4;
    localparam logic [5:0] IDX_PRESCALE = 6'd5;
    localparam logic [5:0] IDX_IRQ_EN   = 6'd6;
    localparam logic [5:0] IDX_IRQ_PEND = 6'd7;
    localparam logic [5:0] IDX_CMP0     = 6'd8;

    // Timer / compare state
    logic [63:0]         timer;
    logic [31:0]         divider;
    logic [31:0]         prescale;
    logic [31:0]         shadow;
    logic [31:0]         cmp [CHANNELS];
    logic [CHANNELS-1:0] irq_en;
    logic [CHANNELS-1:0] irq_pend;

    // Console FIFO state
    logic [7:0]          fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]       rd_ptr;
    logic [PW-1:0]       wr_ptr;
    logic [CW-1:0]       count;

    // Bus response registers
    logic                ready_q;
    logic [31:0]         rdata_q;

    // Decode
    logic [31:0]         offset;
    logic [5:0]          word_idx;
    logic                request;
    logic                console_sel;
    logic                fifo_full;
    logic                fifo_empty;
    logic                push_blocked;
    logic                accept;
    logic                acc_write;
    logic                acc_read;
    logic                word_write;
    logic                push;
    logic                pop;
    logic                tick;
    logic [31:0]         timer_lo_next;
    logic [CHANNELS-1:0] cmp_set;
    logic [CHANNELS-1:0] pend_clr;
    logic [31:0]         rdata;
    logic [CW-1:0]       count_after_pop;
    logic [CW-1:0]       count_next;
    logic [PW-1:0]       rd_next;
    logic [7:0]          head_next;

    // The window test uses the full offset so an address below BASE_ADDR
    // (which wraps to a huge offset) never counts as a hit.
    assign offset   = bus.data_address - BASE_ADDR;
    assign word_idx = offset[7:2];
    assign bus.hit  = (bus.data_address >= BASE_ADDR) && (offset < WINDOW);

    // No acceptance during the ready cycle: the core is still dropping its
    // request there and must not be served twice.
    assign request      = (bus.data_read | bus.data_write) & bus.hit & ~ready_q;
    assign console_sel  = (word_idx == IDX_CONSOLE);
    assign fifo_full    = (count == CW'(FIFO_DEPTH));
    assign fifo_empty   = (count == '0);
    // A push into a full FIFO waits even if a pop happens on the same edge;
    // the freed slot is taken on the following edge.
    assign push_blocked = bus.data_write & console_sel & fifo_full;
    assign accept       = request & ~push_blocked;
    assign acc_write    = accept & bus.data_write;
    assign acc_read     = accept & ~bus.data_write;
    assign word_write   = acc_write & (bus.data_width == 2'd2);
    assign push         = acc_write & console_sel;
    assign pop          = console_valid & console_ready;

    assign tick          = (divider == prescale);
    assign timer_lo_next = timer[31:0] + 32'd1;

    assign bus.data_ready = ready_q;
    assign bus.data_out   = rdata_q;

    // Compare hits are judged against the post-tick timer value, so writing a
    // CMP equal to the current timer never raises pending by itself.
    always_comb begin
        cmp_set = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            cmp_set[k] = tick && (timer_lo_next == cmp[k]);
        end
    end

    always_comb begin
        pend_clr = '0;
        if (word_write && (word_idx == IDX_IRQ_PEND)) begin
            pend_clr = bus.data_in[CHANNELS-1:0];
        end
    end

    // Register read mux; unmapped offsets and write-only registers read as 0.
    always_comb begin
        rdata = '0;
        case (word_idx)
            IDX_TIMER_LO: rdata = timer[31:0];
            IDX_TIMER_HI: rdata = shadow;
            IDX_STATUS: begin
                rdata[CW-1:0] = count;
                rdata[8]      = fifo_full;
                rdata[9]      = fifo_empty;
            end
            IDX_PRESCALE: rdata = prescale;
            IDX_IRQ_EN:   rdata = 32'(irq_en);
            IDX_IRQ_PEND: rdata = 32'(irq_pend);
            default: begin
                for (int k = 0; k < CHANNELS; k++) begin
                    if (word_idx == 6'(IDX_CMP0 + k)) begin
                        rdata = cmp[k];
                    end
                end
            end
        endcase
    end

    // Next-state of the FIFO. When the entry that becomes the head is being
    // written on this same edge, it is taken straight from the bus.
    always_comb begin
        count_after_pop = count - CW'(pop);
        count_next      = count_after_pop + CW'(push);
        rd_next         = rd_ptr + PW'(pop);
        head_next       = (push && (count_after_pop == '0)) ? bus.data_in[7:0]
                                                            : fifo_mem[rd_next];
    end

    // Bus completion: one-cycle ready after every accepted request.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ready_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            ready_q <= accept;
            rdata_q <= acc_read ? rdata : 32'h0;
        end
    end

    // Timer, prescaler, compare channels and interrupt state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            timer    <= '0;
            divider  <= '0;
            prescale <= PRESCALE_DEFAULT;
            shadow   <= '0;
            irq_en   <= '0;
            irq_pend <= '0;
            irq      <= 1'b0;
            for (int k = 0; k < CHANNELS; k++) begin
                cmp[k] <= '0;
            end
        end else begin
            if (tick) begin
                timer <= timer + 64'd1;
            end

            if (word_write && (word_idx == IDX_PRESCALE)) begin
                prescale <= bus.data_in;
                divider  <= '0;
            end else if (tick) begin
                divider <= '0;
            end else begin
                divider <= divider + 32'd1;
            end

            if (acc_read && (word_idx == IDX_TIMER_LO)) begin
                shadow <= timer[63:32];
            end

            if (word_write && (word_idx == IDX_IRQ_EN)) begin
                irq_en <= bus.data_in[CHANNELS-1:0];
            end

            for (int k = 0; k < CHANNELS; k++) begin
                if (word_write && (word_idx == 6'(IDX_CMP0 + k))) begin
                    cmp[k] <= bus.data_in;
                end
            end

            // A compare hit wins over a same-edge clear of the same bit.
            irq_pend <= (irq_pend & ~pend_clr) | cmp_set;
            irq      <= |(irq_pend & irq_en);
        end
    end

    // Console FIFO pointers, occupancy and registered head.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            count         <= '0;
            console_valid <= 1'b0;
            console_data  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count         <= count_next;
            console_valid <= (count_next != '0);
            console_data  <= (count_next != '0) ? head_next : 8'h00;
        end
    end

    // FIFO storage needs no reset; only entries below count are ever shown.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem[wr_ptr] <= bus.data_in[7:0];
        end
    end

endmodule
